steak_drawer: RTL and testbench

Pixel-writer consumer of the steak colour interface. Samples `steakMuscle`/`steakFat` under `writeEN` and rasterises one steak sprite into the VGA adapter's pixel-write port (`x`, `y`, `colour`, `plot`), one pixel per clock. Border pixels are drawn in fat colour and interior pixels in muscle colour. A redraw happens only when the colour pair differs from the last pair drawn. Sits between the steak controller and the VGA adapter.

---
 rtl/steak_drawer.sv | 190 +++++++++++++++++++
 tb/tb_steak_drawer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/steak_drawer.sv
// steak_drawer: rasterises one steak sprite into the VGA pixel-write port, one pixel per clock.
// Optional grill marks on interior pixels are enabled by defining STEAK_GRILL_MARKS_EN.
module steak_drawer #(
    parameter logic [7:0] X_ORIGIN   = 8'd40,
    parameter logic [6:0] Y_ORIGIN   = 7'd30,
    parameter int         WIDTH      = 16,
    parameter int         HEIGHT     = 8,
    parameter int         FAT_BORDER = 1,
    parameter logic [8:0] BG_COLOUR  = 9'b000000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] steakMuscle,
    input  logic [8:0] steakFat,
    input  logic       writeEN,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [8:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

    localparam logic [5:0] COL_LAST   = 6'(WIDTH - 1);
    localparam logic [5:0] ROW_LAST   = 6'(HEIGHT - 1);
    localparam logic [5:0] FAT_LO     = 6'(FAT_BORDER);
    localparam logic [5:0] COL_FAT_HI = 6'(WIDTH - FAT_BORDER);
    localparam logic [5:0] ROW_FAT_HI = 6'(HEIGHT - FAT_BORDER);

    state_t     state_q, state_d;
    logic [8:0] lastMuscle_q, lastMuscle_d;
    logic [8:0] lastFat_q, lastFat_d;
    logic       lastValid_q, lastValid_d;
    logic [8:0] latMuscle_q, latMuscle_d;
    logic [8:0] latFat_q, latFat_d;
    logic [5:0] col_q, col_d;
    logic [5:0] row_q, row_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [8:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       emit;
    logic [5:0] pixCol;
    logic [5:0] pixRow;
    logic       isFat;
    logic [8:0] pixColour;

    // The pair is captured on entry to LATCH, so anything that changes afterwards is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            lastMuscle_q <= '0;
            lastFat_q    <= '0;
            lastValid_q  <= 1'b0;
            latMuscle_q  <= '0;
            latFat_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastMuscle_q <= lastMuscle_d;
            lastFat_q    <= lastFat_d;
            lastValid_q  <= lastValid_d;
            latMuscle_q  <= latMuscle_d;
            latFat_q     <= latFat_d;
            col_q        <= col_d;
            row_q        <= row_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Outputs are computed for the pixel the counters will hold next cycle, keeping them registered.
    always_comb begin
        state_d      = state_q;
        lastMuscle_d = lastMuscle_q;
        lastFat_d    = lastFat_q;
        lastValid_d  = lastValid_q;
        latMuscle_d  = latMuscle_q;
        latFat_d     = latFat_q;
        col_d        = col_q;
        row_d        = row_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        emit         = 1'b0;
        pixCol       = col_q;
        pixRow       = row_q;

        case (state_q)
            IDLE: begin
                if (writeEN && (!lastValid_q || steakMuscle != lastMuscle_q ||
                                steakFat != lastFat_q)) begin
                    state_d      = LATCH;
                    lastMuscle_d = steakMuscle;
                    lastFat_d    = steakFat;
                    lastValid_d  = 1'b1;
                    latMuscle_d  = steakMuscle;
                    latFat_d     = steakFat;
                    busy_d       = 1'b1;
                end
            end
            LATCH: begin
                state_d = DRAW;
                col_d   = '0;
                row_d   = '0;
                pixCol  = '0;
                pixRow  = '0;
                emit    = 1'b1;
                busy_d  = 1'b1;
            end
            DRAW: begin
                busy_d = 1'b1;
                if (col_q == COL_LAST && row_q == ROW_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 6'd1;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                    pixCol = col_d;
                    pixRow = row_d;
                    emit   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        x_d      = '0;
        y_d      = '0;
        colour_d = '0;
        plot_d   = emit;
        if (emit) begin
            x_d      = X_ORIGIN + {2'b00, pixCol};
            y_d      = Y_ORIGIN + {1'b0, pixRow};
            colour_d = pixColour;
        end
    end

`ifdef STEAK_GRILL_MARKS_EN
    logic [1:0] grillSum;
    assign grillSum = pixCol[1:0] + pixRow[1:0];
`endif

    // An all-zero latched pair means the steak is gone, so the sprite area is erased.
    always_comb begin
        isFat = (pixCol < FAT_LO) || (pixCol >= COL_FAT_HI) ||
                (pixRow < FAT_LO) || (pixRow >= ROW_FAT_HI);
        pixColour = latMuscle_q;
        if (latMuscle_q == '0 && latFat_q == '0) begin
            pixColour = BG_COLOUR;
        end else if (isFat) begin
            pixColour = latFat_q;
`ifdef STEAK_GRILL_MARKS_EN
        end else if (grillSum == 2'd0) begin
            pixColour = '0;
`endif
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_steak_drawer.sv
// Scoreboard bench for steak_drawer: expected pixels are queued when a draw is requested
// and popped as the DUT plots; a second instance exercises the wider grill-mark sprite.
module tb_steak_drawer;

    localparam int         W   = 4;
    localparam int         H   = 3;
    localparam int         WG  = 6;
    localparam int         HG  = 4;
    localparam int         FB  = 1;
    localparam int         X0  = 10;
    localparam int         Y0  = 5;
    localparam logic [8:0] BG  = 9'h003;
`ifdef STEAK_GRILL_MARKS_EN
    localparam bit GRILL = 1'b1;
`else
    localparam bit GRILL = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] steakMuscle = '0;
    logic [8:0] steakFat = '0;
    logic       writeEN = 1'b0;
    logic       writeENG = 1'b0;
    logic [7:0] x, xG;
    logic [6:0] y, yG;
    logic [8:0] colour, colourG;
    logic       plot, plotG, busy, busyG, done, doneG;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] q[$];
    logic [23:0] qG[$];
    logic [8:0]  gridG [0:WG-1][0:HG-1];

    always #5 clock = ~clock;

    steak_drawer #(.X_ORIGIN(8'(X0)), .Y_ORIGIN(7'(Y0)), .WIDTH(W), .HEIGHT(H),
                   .FAT_BORDER(FB), .BG_COLOUR(BG)) dut (
        .clock(clock), .reset(reset), .steakMuscle(steakMuscle), .steakFat(steakFat),
        .writeEN(writeEN), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done));

    steak_drawer #(.X_ORIGIN(8'(X0)), .Y_ORIGIN(7'(Y0)), .WIDTH(WG), .HEIGHT(HG),
                   .FAT_BORDER(FB), .BG_COLOUR(BG)) dutG (
        .clock(clock), .reset(reset), .steakMuscle(steakMuscle), .steakFat(steakFat),
        .writeEN(writeENG), .x(xG), .y(yG), .colour(colourG), .plot(plotG), .busy(busyG),
        .done(doneG));

    function automatic logic [23:0] expPixel(int w, int h, int c, int r,
                                             logic [8:0] m, logic [8:0] f, bit grill);
        logic [8:0] col;
        if (m == 9'd0 && f == 9'd0) col = BG;
        else if (c < FB || c >= w - FB || r < FB || r >= h - FB) col = f;
        else if (grill && ((c + r) % 4 == 0)) col = 9'd0;
        else col = m;
        return {8'(X0 + c), 7'(Y0 + r), col};
    endfunction

    task automatic pushFrame(input logic [8:0] m, input logic [8:0] f, input int count);
        int n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (n < count) begin
                    q.push_back(expPixel(W, H, c, r, m, f, 1'b0));
                    n++;
                end
    endtask

    always @(negedge clock) begin
        if (plot) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_plot got x=%0d y=%0d colour=%h want no plot",
                         x, y, colour);
            end else begin
                logic [23:0] e;
                e = q.pop_front();
                if ({x, y, colour} !== e)
                    begin
                        miscompares++;
                        $display("[TB] FAIL pixel got x=%0d y=%0d colour=%h want x=%0d y=%0d colour=%h",
                                 x, y, colour, e[23:16], e[15:9], e[8:0]);
                    end
            end
        end
        if (plotG) begin
            vectors++;
            if (int'(xG) - X0 >= 0 && int'(xG) - X0 < WG && int'(yG) - Y0 >= 0 && int'(yG) - Y0 < HG)
                gridG[int'(xG) - X0][int'(yG) - Y0] = colourG;
            if (qG.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_plotG got x=%0d y=%0d colour=%h want no plot",
                         xG, yG, colourG);
            end else begin
                logic [23:0] e;
                e = qG.pop_front();
                if ({xG, yG, colourG} !== e) begin
                    miscompares++;
                    $display("[TB] FAIL pixelG got x=%0d y=%0d colour=%h want x=%0d y=%0d colour=%h",
                             xG, yG, colourG, e[23:16], e[15:9], e[8:0]);
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({plot, busy, done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got plot/busy/done=%b want 000", {plot, busy, done});
        end
        vectors++;
        if ({x, y, colour} !== 24'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_coords got x=%0d y=%0d colour=%h want 0 0 000", x, y, colour);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic_draw;
        int k = 0;
        int firstPlot = 0;
        bit seen = 0;
        @(negedge clock);
        steakMuscle = 9'h1C0;
        steakFat = 9'h1FF;
        writeEN = 1'b1;
        pushFrame(9'h1C0, 9'h1FF, W * H);
        while (!seen && k < 60) begin
            @(posedge clock);
            #1;
            k++;
            if (plot && firstPlot == 0) firstPlot = k;
            if (done) seen = 1;
        end
        vectors++;
        if (firstPlot != 2) begin
            miscompares++;
            $display("[TB] FAIL first_plot_latency got %0d want 2", firstPlot);
        end
        vectors++;
        if (k != 2 + W * H || !seen) begin
            miscompares++;
            $display("[TB] FAIL done_latency got %0d (seen=%0d) want %0d", k, seen, 2 + W * H);
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL basic_pixels_left got %0d want 0", q.size());
        end
        @(posedge clock);
        #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL after_done got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_redundant;
        int busyCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (busy) busyCycles++;
        end
        vectors++;
        if (busyCycles != 0) begin
            miscompares++;
            $display("[TB] FAIL redundant_busy got %0d busy cycles want 0", busyCycles);
        end
    endtask

    task automatic waitDone(input string tag);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (done) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL %s_done_timeout got no done want done within 60 cycles", tag);
        end
    endtask

    task automatic test_change_mid_draw;
        logic [2:0] plotSeq;
        @(negedge clock);
        steakMuscle = 9'h038;
        steakFat = 9'h1FF;
        pushFrame(9'h038, 9'h1FF, W * H);
        repeat (6) @(negedge clock);
        steakFat = 9'h0F0;
        pushFrame(9'h038, 9'h0F0, W * H);
        waitDone("change_first");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            plotSeq[i] = plot;
        end
        vectors++;
        if (plotSeq !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL redraw_start got plot seq (3rd..1st)=%b want 100", plotSeq);
        end
        waitDone("change_second");
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL change_pixels_left got %0d want 0", q.size());
        end
    endtask

    task automatic test_erase;
        @(negedge clock);
        steakMuscle = 9'h000;
        steakFat = 9'h000;
        pushFrame(9'h000, 9'h000, W * H);
        waitDone("erase");
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL erase_pixels_left got %0d want 0", q.size());
        end
    endtask

    task automatic test_reset_mid_draw;
        int n = 0;
        @(negedge clock);
        steakMuscle = 9'h1C0;
        steakFat = 9'h1FF;
        pushFrame(9'h1C0, 9'h1FF, 5);
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clock);
            if (plot) n++;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if ({plot, busy} !== 2'b00 || {x, y, colour} !== 24'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_draw got plot=%b busy=%b x=%0d y=%0d colour=%h want all 0",
                     plot, busy, x, y, colour);
        end
        @(negedge clock);
        pushFrame(9'h1C0, 9'h1FF, W * H);
        reset = 1'b0;
        waitDone("reset_redraw");
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_redraw_pixels_left got %0d want 0", q.size());
        end
    endtask

    task automatic test_grill;
        bit seen = 0;
        @(negedge clock);
        writeEN = 1'b0;
        steakMuscle = 9'h1C0;
        steakFat = 9'h1FF;
        writeENG = 1'b1;
        for (int r = 0; r < HG; r++)
            for (int c = 0; c < WG; c++)
                qG.push_back(expPixel(WG, HG, c, r, 9'h1C0, 9'h1FF, GRILL));
        for (int i = 0; i < 80 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (doneG) seen = 1;
        end
        vectors++;
        if (!seen || qG.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL grill_frame got done=%0d left=%0d want done=1 left=0", seen, qG.size());
        end
        vectors++;
        if (gridG[2][2] !== (GRILL ? 9'h000 : 9'h1C0)) begin
            miscompares++;
            $display("[TB] FAIL grill_c2r2 got %h want %h", gridG[2][2], GRILL ? 9'h000 : 9'h1C0);
        end
        vectors++;
        if (gridG[1][1] !== 9'h1C0) begin
            miscompares++;
            $display("[TB] FAIL grill_c1r1 got %h want 1c0", gridG[1][1]);
        end
        writeENG = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < WG; c++)
            for (int r = 0; r < HG; r++)
                gridG[c][r] = 9'h1AA;
        test_reset;
        test_basic_draw;
        test_redundant;
        test_change_mid_draw;
        test_erase;
        test_reset_mid_draw;
        test_grill;
        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
